// File: rtl/player_move_ctrl_pkg.sv
// Shared constants and types for the player move sequencer, ui_render and the game FSM.
package player_move_ctrl_pkg;

  localparam int N_TILES     = 16;   // tile N_TILES-1 is the goal
  localparam int TILE_W      = 36;   // tile pitch in pixels, multiple of PIX_PER_FRM
  localparam int START_X     = 40;   // x pixel of tile 0
  localparam int LANE1_Y     = 300;  // rest y of player 1
  localparam int LANE2_Y     = 340;  // rest y of player 2
  localparam int PIX_PER_FRM = 4;    // pixels advanced per frame tick
  localparam int HOP_H_SHIFT = 1;    // hop height divider (as a shift)

  localparam int TILE_BITS = $clog2(N_TILES);
  localparam int OFF_BITS  = $clog2(TILE_W + 1);

  typedef enum logic [1:0] {IDLE, MOVE, DONE} move_state_t;

  typedef logic [TILE_BITS-1:0] tile_idx_t;
  typedef logic [OFF_BITS-1:0]  tile_off_t;

endpackage

// File: rtl/player_move_ctrl_if.sv
// Move request handshake between the game FSM (master) and the move sequencer (slave).
interface player_move_ctrl_if;

  logic       move_req;
  logic       move_ready;
  logic       move_player;
  logic [2:0] move_steps;
  logic       move_done;

  modport master (
    output move_req,
    output move_player,
    output move_steps,
    input  move_ready,
    input  move_done
  );

  modport slave (
    input  move_req,
    input  move_player,
    input  move_steps,
    output move_ready,
    output move_done
  );

endinterface

// File: rtl/player_move_ctrl_tile_to_px.sv
// Combinational tile/offset to sprite pixel position.
// Optional PLAYER_HOP_EN: triangular hop of each tile on the y axis.
module tile_to_px
  import player_move_ctrl_pkg::*;
#(
  parameter int LANE_Y = LANE1_Y
) (
  input  tile_idx_t   tile,
  input  tile_off_t   offset,
  output logic [9:0]  x,
  output logic [9:0]  y
);

  // Track position: tile pitch plus the in-tile offset of the mover.
  assign x = 10'(START_X + int'(tile) * TILE_W + int'(offset));

`ifdef PLAYER_HOP_EN
  tile_off_t rem_off;
  tile_off_t hop_base;

  // Distance to the nearer tile edge gives a hop peaking mid-tile.
  always_comb begin
    rem_off  = OFF_BITS'(TILE_W) - offset;
    hop_base = (offset < rem_off) ? offset : rem_off;
    y        = 10'(LANE_Y - (int'(hop_base) >> HOP_H_SHIFT));
  end
`else
  assign y = 10'(LANE_Y);
`endif

endmodule

// File: rtl/player_move_ctrl.sv
// Player move sequencer: accepts one dice move, animates the mover tile by tile on
// frame ticks, pulses move_done and latches the first player to reach the goal.
// Optional feature macro: PLAYER_HOP_EN (hop animation on the mover's y).
module player_move_ctrl
  import player_move_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic                     game_clr,
  player_move_ctrl_if.slave        mv,
  output logic                     winner_valid,
  output logic                     winner_id,
  output logic [9:0]               player1_x,
  output logic [9:0]               player1_y,
  output logic [9:0]               player2_x,
  output logic [9:0]               player2_y
);

  move_state_t state;
  logic        mover;
  logic [2:0]  steps_left;
  tile_idx_t   tile1;
  tile_idx_t   tile2;
  tile_off_t   offset;
  logic        ready_q;
  logic        done_q;

  tile_idx_t   cur_tile;
  tile_off_t   off1;
  tile_off_t   off2;

  assign cur_tile      = mover ? tile2 : tile1;
  assign off1          = (mover == 1'b0) ? offset : '0;
  assign off2          = (mover == 1'b1) ? offset : '0;
  assign mv.move_ready = ready_q;
  assign mv.move_done  = done_q;

  // Move FSM: accept, per-tick advance with goal clamp, single-cycle done + winner latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      mover        <= 1'b0;
      steps_left   <= '0;
      tile1        <= '0;
      tile2        <= '0;
      offset       <= '0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      winner_valid <= 1'b0;
      winner_id    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (game_clr) begin
        state        <= IDLE;
        steps_left   <= '0;
        tile1        <= '0;
        tile2        <= '0;
        offset       <= '0;
        ready_q      <= 1'b1;
        winner_valid <= 1'b0;
        winner_id    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (mv.move_req) begin
              mover      <= mv.move_player;
              steps_left <= mv.move_steps;
              ready_q    <= 1'b0;
              // Zero steps or a decided game: complete without motion.
              if (mv.move_steps == 3'd0 || winner_valid) state <= DONE;
              else                                       state <= MOVE;
            end
          end
          MOVE: begin
            if (frame_tick) begin
              if (offset == OFF_BITS'(TILE_W - PIX_PER_FRM)) begin
                offset     <= '0;
                steps_left <= steps_left - 3'd1;
                if (mover) tile2 <= tile2 + 1'b1;
                else       tile1 <= tile1 + 1'b1;
                // Goal clamps: any remaining steps are dropped.
                if (steps_left == 3'd1 || cur_tile == TILE_BITS'(N_TILES - 2))
                  state <= DONE;
              end else begin
                offset <= offset + OFF_BITS'(PIX_PER_FRM);
              end
            end
          end
          DONE: begin
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state   <= IDLE;
            if (cur_tile == TILE_BITS'(N_TILES - 1) && !winner_valid) begin
              winner_valid <= 1'b1;
              winner_id    <= mover;
            end
          end
          default: begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  tile_to_px #(.LANE_Y(LANE1_Y)) u_px1 (
    .tile   (tile1),
    .offset (off1),
    .x      (player1_x),
    .y      (player1_y)
  );

  tile_to_px #(.LANE_Y(LANE2_Y)) u_px2 (
    .tile   (tile2),
    .offset (off2),
    .x      (player2_x),
    .y      (player2_y)
  );

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl.
module tb_player_move_ctrl;

`ifdef PLAYER_HOP_EN
  localparam int HOP_Y16 = 292;
`else
  localparam int HOP_Y16 = 300;
`endif

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic       game_clr;
  logic       winner_valid;
  logic       winner_id;
  logic [9:0] player1_x, player1_y, player2_x, player2_y;

  int n_cmp;
  int n_err;
  int done_cnt;
  int d0;

  player_move_ctrl_if mif ();

  player_move_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .game_clr     (game_clr),
    .mv           (mif),
    .winner_valid (winner_valid),
    .winner_id    (winner_id),
    .player1_x    (player1_x),
    .player1_y    (player1_y),
    .player2_x    (player2_x),
    .player2_y    (player2_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count move_done pulses seen at clock edges.
  always @(posedge clk) begin
    if (!reset && mif.move_done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      cyc(1);
    end
  endtask

  task automatic accept(input logic p, input logic [2:0] s, input logic tk);
    mif.move_req    = 1'b1;
    mif.move_player = p;
    mif.move_steps  = s;
    frame_tick      = tk;
    cyc(1);
    mif.move_req = 1'b0;
    frame_tick   = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; done_cnt = 0;
    reset = 1'b1; frame_tick = 1'b0; game_clr = 1'b0;
    mif.move_req = 1'b0; mif.move_player = 1'b0; mif.move_steps = 3'd0;
    cyc(2);
    reset = 1'b0;
    cyc(1);

    // Reset state
    chk("rst_p1x", player1_x, 40);
    chk("rst_p1y", player1_y, 300);
    chk("rst_p2x", player2_x, 40);
    chk("rst_p2y", player2_y, 340);
    chk("rst_ready", mif.move_ready, 1);
    chk("rst_winv", winner_valid, 0);
    chk("rst_done", mif.move_done, 0);

    // P1 three steps; tick in the accept cycle must not count
    accept(1'b0, 3'd3, 1'b1);
    chk("t2_acc_x", player1_x, 40);
    chk("t2_acc_ready", mif.move_ready, 0);
    ticks(26);
    chk("t2_x26", player1_x, 144);
    chk("t2_done_early", mif.move_done, 0);
    ticks(1);
    chk("t2_x27", player1_x, 148);
    chk("t2_done", mif.move_done, 1);
    cyc(1);
    chk("t2_done_off", mif.move_done, 0);
    chk("t2_ready", mif.move_ready, 1);
    chk("t2_cnt", done_cnt, 1);

    // Request while busy is ignored
    d0 = done_cnt;
    accept(1'b0, 3'd2, 1'b0);
    mif.move_req = 1'b1; mif.move_player = 1'b1; mif.move_steps = 3'd7;
    cyc(1);
    chk("t4_busy_ready", mif.move_ready, 0);
    ticks(3);
    mif.move_req = 1'b0;
    ticks(15);
    cyc(2);
    chk("t4_p1x", player1_x, 220);
    chk("t4_p2x", player2_x, 40);
    chk("t4_cnt", done_cnt - d0, 1);

    // Zero steps: done two cycles after accept, no motion
    accept(1'b1, 3'd0, 1'b0);
    chk("t4z_done_a1", mif.move_done, 0);
    cyc(1);
    chk("t4z_done_a2", mif.move_done, 1);
    chk("t4z_p2x", player2_x, 40);
    chk("t4z_p1x", player1_x, 220);

    // P2 to tile 13, then clamp at the goal
    cyc(2);
    accept(1'b1, 3'd7, 1'b0);
    ticks(63);
    cyc(2);
    chk("t3_p2x_t7", player2_x, 292);
    accept(1'b1, 3'd6, 1'b0);
    ticks(54);
    cyc(2);
    chk("t3_p2x_t13", player2_x, 508);
    chk("t3_winv_pre", winner_valid, 0);
    d0 = done_cnt;
    accept(1'b1, 3'd6, 1'b0);
    ticks(24);
    cyc(2);
    chk("t3_p2x_goal", player2_x, 580);
    chk("t3_winv", winner_valid, 1);
    chk("t3_winid", winner_id, 1);
    chk("t3_cnt", done_cnt - d0, 1);
    d0 = done_cnt;
    accept(1'b0, 3'd7, 1'b0);
    ticks(5);
    cyc(2);
    chk("t3_p1_static", player1_x, 220);
    chk("t3_winid_keep", winner_id, 1);
    chk("t3_cnt2", done_cnt - d0, 1);

    // game_clr pulse, then clear mid-move together with a frame tick
    game_clr = 1'b1;
    cyc(1);
    game_clr = 1'b0;
    chk("t5_clr_p1x", player1_x, 40);
    chk("t5_clr_p2x", player2_x, 40);
    chk("t5_clr_winv", winner_valid, 0);
    chk("t5_clr_winid", winner_id, 0);
    accept(1'b0, 3'd3, 1'b0);
    ticks(5);
    chk("t5_mid_x", player1_x, 60);
    d0 = done_cnt;
    game_clr = 1'b1; frame_tick = 1'b1;
    cyc(1);
    game_clr = 1'b0; frame_tick = 1'b0;
    chk("t5_abort_x", player1_x, 40);
    chk("t5_abort_ready", mif.move_ready, 1);
    chk("t5_abort_done", mif.move_done, 0);
    ticks(2);
    cyc(2);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_static_x", player1_x, 40);

    // Hop height at mid-tile offsets and back on the tile edge
    accept(1'b0, 3'd1, 1'b0);
    ticks(4);
    chk("t6_x16", player1_x, 56);
    chk("t6_y16", player1_y, HOP_Y16);
    chk("t6_p2y", player2_y, 340);
    ticks(5);
    chk("t6_x36", player1_x, 76);
    chk("t6_y0", player1_y, 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
